pwm_multi: RTL

PWM_MULTI -- requirements
Module: pwm_multi

---
 rtl/pwm_multi.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator with double-buffered settings.
//
// A shared counter runs in edge-aligned (0..P, period P+1) or center-aligned
// (0..P..1, period 2P) mode. Each channel drives its output high while the
// counter is below that channel's duty value. New period/duty/mode values are
// captured into a staging set on `load` and moved to the active set only at a
// period boundary, so a running period is never disturbed.
//
// Parameters:
//   N  - counter / period / duty width in bits (N >= 2)
//   CH - number of PWM channels (CH >= 1)
//
// Ports:
//   clk          - clock, rising edge
//   clr          - synchronous active-high reset, highest priority
//   en           - counter run enable; low holds counter at 0, outputs low
//   load         - one-cycle strobe capturing period/duty/mode into staging
//   mode         - 0 = edge-aligned, 1 = center-aligned
//   period       - period value P
//   duty         - per-channel duty, channel i in bits [i*N +: N]
//   pwm          - registered PWM outputs
//   period_end   - one-cycle pulse in the cycle after each period boundary
//   load_pending - staged values waiting for the next boundary
module pwm_multi #(
  parameter int unsigned N  = 8,
  parameter int unsigned CH = 4
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            en,
  input  logic            load,
  input  logic            mode,
  input  logic [N-1:0]    period,
  input  logic [CH*N-1:0] duty,
  output logic [CH-1:0]   pwm,
  output logic            period_end,
  output logic            load_pending
);

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } mode_e;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  // Counter state
  logic [N-1:0]    cnt_q, cnt_d;
  dir_e            dir_q, dir_d;

  // Staging register set
  logic [N-1:0]    stg_period_q, stg_period_d;
  logic [CH*N-1:0] stg_duty_q, stg_duty_d;
  mode_e           stg_mode_q, stg_mode_d;

  // Active register set (the only one used for counting and comparison)
  logic [N-1:0]    act_period_q, act_period_d;
  logic [CH*N-1:0] act_duty_q, act_duty_d;
  mode_e           act_mode_q, act_mode_d;

  logic            pend_q, pend_d;
  logic [CH-1:0]   pwm_q, pwm_d;
  logic            pe_q, pe_d;

  logic            boundary;

  // Boundary = the counter returns to 0 on the next edge.
  // Center mode with P=1 has no down-count steps, so its boundary is at the
  // top while still counting up.
  always_comb begin
    boundary = 1'b0;
    if (act_period_q == '0) begin
      boundary = 1'b1;
    end else if (act_mode_q == MODE_EDGE) begin
      boundary = (cnt_q >= act_period_q);
    end else if (dir_q == DIR_DOWN) begin
      boundary = (cnt_q <= ONE);
    end else begin
      boundary = (act_period_q == ONE) && (cnt_q >= ONE);
    end
  end

  // Counter next state
  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (!en || boundary) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (act_mode_q == MODE_EDGE) begin
      cnt_d = cnt_q + ONE;
    end else if (dir_q == DIR_UP) begin
      if (cnt_q >= act_period_q) begin
        cnt_d = cnt_q - ONE;
        dir_d = DIR_DOWN;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end else begin
      cnt_d = cnt_q - ONE;
    end
  end

  // Register-set transfer. When load and a pending transfer coincide at a
  // boundary, active takes the old staging contents (read from _q) while
  // staging takes the new inputs, leaving load_pending set.
  always_comb begin
    stg_period_d = stg_period_q;
    stg_duty_d   = stg_duty_q;
    stg_mode_d   = stg_mode_q;
    act_period_d = act_period_q;
    act_duty_d   = act_duty_q;
    act_mode_d   = act_mode_q;
    pend_d       = pend_q;
    if (!en) begin
      pend_d = 1'b0;
      if (load) begin
        stg_period_d = period;
        stg_duty_d   = duty;
        stg_mode_d   = mode_e'(mode);
        act_period_d = period;
        act_duty_d   = duty;
        act_mode_d   = mode_e'(mode);
      end
    end else begin
      if (boundary && pend_q) begin
        act_period_d = stg_period_q;
        act_duty_d   = stg_duty_q;
        act_mode_d   = stg_mode_q;
        pend_d       = 1'b0;
      end
      if (load) begin
        stg_period_d = period;
        stg_duty_d   = duty;
        stg_mode_d   = mode_e'(mode);
        pend_d       = 1'b1;
      end
    end
  end

  // Compare stage: outputs lag the counter by one cycle.
  always_comb begin
    pwm_d = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      pwm_d[i] = en && (cnt_q < act_duty_q[i*N +: N]);
    end
    pe_d = en && boundary;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q        <= '0;
      dir_q        <= DIR_UP;
      stg_period_q <= '0;
      stg_duty_q   <= '0;
      stg_mode_q   <= MODE_EDGE;
      act_period_q <= '0;
      act_duty_q   <= '0;
      act_mode_q   <= MODE_EDGE;
      pend_q       <= 1'b0;
      pwm_q        <= '0;
      pe_q         <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      stg_period_q <= stg_period_d;
      stg_duty_q   <= stg_duty_d;
      stg_mode_q   <= stg_mode_d;
      act_period_q <= act_period_d;
      act_duty_q   <= act_duty_d;
      act_mode_q   <= act_mode_d;
      pend_q       <= pend_d;
      pwm_q        <= pwm_d;
      pe_q         <= pe_d;
    end
  end

  assign pwm          = pwm_q;
  assign period_end   = pe_q;
  assign load_pending = pend_q;

endmodule
